// File: rtl/postfix_eval_if.sv
// Token, result and status signals of the postfix evaluator.
// master = token producer / result consumer, slave = evaluator.
interface postfix_eval_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    logic [7:0]              NUMBER_IN;
    logic                    NUMBER_STB;
    logic                    NUMBER_ACK;
    logic [7:0]              SIGN_IN;
    logic                    SIGN_STB;
    logic                    SIGN_ACK;
    logic [DATA_W-1:0]       RESULT;
    logic [2:0]              ERR;
    logic                    RESULT_STB;
    logic                    RESULT_ACK;
    logic                    BUSY;
    logic [$clog2(DEPTH):0]  DEPTH_OUT;
    logic [2:0]              STATE_DBG;

    // Tokens: *_STB is held until the one-cycle *_ACK pulse. Both STBs high
    // together mean end of expression. RESULT_STB is held until RESULT_ACK.
    modport master (
        output NUMBER_IN, NUMBER_STB, SIGN_IN, SIGN_STB, RESULT_ACK,
        input  NUMBER_ACK, SIGN_ACK, RESULT, ERR, RESULT_STB, BUSY, DEPTH_OUT, STATE_DBG
    );
    modport slave (
        input  NUMBER_IN, NUMBER_STB, SIGN_IN, SIGN_STB, RESULT_ACK,
        output NUMBER_ACK, SIGN_ACK, RESULT, ERR, RESULT_STB, BUSY, DEPTH_OUT, STATE_DBG
    );
endinterface

// File: rtl/postfix_eval.sv
// Postfix expression evaluator with an operand stack and an iterative divider.
// Define POSTFIX_EVAL_SAT_EN for saturating arithmetic (reported as ERR=6).
module postfix_eval #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input logic           CLK,
    input logic           RST,
    postfix_eval_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W) + 1;
`ifdef POSTFIX_EVAL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [7:0] OP_ADD = 8'd43, OP_SUB = 8'd45, OP_MUL = 8'd42, OP_DIV = 8'd47;

    typedef enum logic [2:0] {IDLE, POP_B, POP_A, EXEC, DIV, PUSH, RESULT, ERROR} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   stack_q [DEPTH];
    logic [AW:0]         sp_q;
    logic                num_ack_q, num_ack_d, sign_ack_q, sign_ack_d;
    logic [2:0]          err_q, err_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [7:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q, res_q, quo_q, rem_q;
    logic                neg_q, sat_q;
    logic [CW-1:0]       cnt_q;

    logic                push_en, pop_en, clear_en, latch_op;
    logic [DATA_W-1:0]   push_val, top;
    logic                end_tok, num_tok, sign_tok, op_ok;
    logic [DATA_W:0]     sum_x, dif_x, rem_sh, trial;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   alu_val, a_mag, b_mag, div_val;
    logic                alu_ovf, sat_neg, div_ovf;

    // An input token is ignored during its own ACK cycle so a held strobe is not counted twice.
    assign end_tok  = bus.NUMBER_STB && bus.SIGN_STB && !num_ack_q && !sign_ack_q;
    assign num_tok  = bus.NUMBER_STB && !bus.SIGN_STB && !num_ack_q;
    assign sign_tok = bus.SIGN_STB && !bus.NUMBER_STB && !sign_ack_q;
    assign op_ok    = (bus.SIGN_IN == OP_ADD) || (bus.SIGN_IN == OP_SUB) ||
                      (bus.SIGN_IN == OP_MUL) || (bus.SIGN_IN == OP_DIV);
    assign top      = stack_q[sp_q[AW-1:0] - AW'(1)];

    always_comb begin
        sum_x   = {a_q[DATA_W-1], a_q} + {b_q[DATA_W-1], b_q};
        dif_x   = {a_q[DATA_W-1], a_q} - {b_q[DATA_W-1], b_q};
        prod    = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
        alu_val = sum_x[DATA_W-1:0];
        alu_ovf = sum_x[DATA_W] ^ sum_x[DATA_W-1];
        sat_neg = sum_x[DATA_W];
        case (op_q)
            OP_SUB: begin
                alu_val = dif_x[DATA_W-1:0];
                alu_ovf = dif_x[DATA_W] ^ dif_x[DATA_W-1];
                sat_neg = dif_x[DATA_W];
            end
            OP_MUL: begin
                alu_val = prod[DATA_W-1:0];
                alu_ovf = prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod[2*DATA_W-1]}};
                sat_neg = prod[2*DATA_W-1];
            end
            default: ;
        endcase
        if (SAT_EN && alu_ovf) alu_val = sat_neg ? S_MIN : S_MAX;

        a_mag  = a_q[DATA_W-1] ? (~a_q) + DATA_W'(1) : a_q;
        b_mag  = b_q[DATA_W-1] ? (~b_q) + DATA_W'(1) : b_q;
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        trial  = rem_sh - {1'b0, b_mag};
        // A positive quotient with the top bit set only comes from MIN / -1.
        div_ovf = !neg_q && quo_q[DATA_W-1];
        div_val = neg_q ? (~quo_q) + DATA_W'(1) : quo_q;
        if (SAT_EN && div_ovf) div_val = S_MAX;
    end

    always_comb begin
        state_d    = state_q;
        num_ack_d  = 1'b0;
        sign_ack_d = 1'b0;
        err_d      = err_q;
        result_d   = result_q;
        push_en    = 1'b0;
        pop_en     = 1'b0;
        clear_en   = 1'b0;
        latch_op   = 1'b0;
        push_val   = {{(DATA_W-8){1'b0}}, bus.NUMBER_IN};
        case (state_q)
            IDLE: begin
                if (end_tok) begin
                    num_ack_d  = 1'b1;
                    sign_ack_d = 1'b1;
                    if (sp_q == (AW+1)'(1)) begin
                        pop_en   = 1'b1;
                        result_d = top;
                        err_d    = sat_q ? 3'd6 : 3'd0;
                        state_d  = RESULT;
                    end else begin
                        result_d = '0;
                        err_d    = 3'd5;
                        state_d  = ERROR;
                    end
                end else if (num_tok) begin
                    num_ack_d = 1'b1;
                    if (sp_q == (AW+1)'(DEPTH)) begin
                        result_d = '0;
                        err_d    = 3'd2;
                        state_d  = ERROR;
                    end else begin
                        push_en = 1'b1;
                    end
                end else if (sign_tok) begin
                    sign_ack_d = 1'b1;
                    latch_op   = 1'b1;
                    if (!op_ok) begin
                        result_d = '0;
                        err_d    = 3'd4;
                        state_d  = ERROR;
                    end else if (sp_q < (AW+1)'(2)) begin
                        result_d = '0;
                        err_d    = 3'd1;
                        state_d  = ERROR;
                    end else begin
                        state_d = POP_B;
                    end
                end
            end
            POP_B: begin
                pop_en  = 1'b1;
                state_d = POP_A;
            end
            POP_A: begin
                pop_en  = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                if (op_q != OP_DIV) begin
                    state_d = PUSH;
                end else if (b_q == '0) begin
                    result_d = '0;
                    err_d    = 3'd3;
                    state_d  = ERROR;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (cnt_q == CW'(DATA_W-1)) state_d = PUSH;
            end
            PUSH: begin
                push_en  = 1'b1;
                push_val = (op_q == OP_DIV) ? div_val : res_q;
                state_d  = IDLE;
            end
            RESULT: begin
                if (bus.RESULT_ACK) begin
                    clear_en = 1'b1;
                    result_d = '0;
                    err_d    = 3'd0;
                    state_d  = IDLE;
                end
            end
            ERROR: begin
                num_ack_d  = bus.NUMBER_STB && !num_ack_q;
                sign_ack_d = bus.SIGN_STB && !sign_ack_q;
                if (bus.RESULT_ACK) begin
                    clear_en = 1'b1;
                    result_d = '0;
                    err_d    = 3'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sp_q       <= '0;
            num_ack_q  <= 1'b0;
            sign_ack_q <= 1'b0;
            err_q      <= 3'd0;
            result_q   <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            neg_q      <= 1'b0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_ack_q  <= num_ack_d;
            sign_ack_q <= sign_ack_d;
            err_q      <= err_d;
            result_q   <= result_d;
            if (clear_en) begin
                sp_q  <= '0;
                sat_q <= 1'b0;
            end else if (push_en) begin
                sp_q <= sp_q + (AW+1)'(1);
            end else if (pop_en) begin
                sp_q <= sp_q - (AW+1)'(1);
            end
            if (latch_op) op_q <= bus.SIGN_IN;
            case (state_q)
                POP_B: b_q <= top;
                POP_A: a_q <= top;
                EXEC: begin
                    res_q <= alu_val;
                    if (SAT_EN && alu_ovf && op_q != OP_DIV) sat_q <= 1'b1;
                    rem_q <= '0;
                    quo_q <= a_mag;
                    neg_q <= a_q[DATA_W-1] ^ b_q[DATA_W-1];
                    cnt_q <= '0;
                end
                DIV: begin
                    quo_q <= {quo_q[DATA_W-2:0], !trial[DATA_W]};
                    rem_q <= trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
                    cnt_q <= cnt_q + CW'(1);
                end
                PUSH: begin
                    if (SAT_EN && div_ovf && op_q == OP_DIV) sat_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_en) stack_q[sp_q[AW-1:0]] <= push_val;
    end

    assign bus.NUMBER_ACK = num_ack_q;
    assign bus.SIGN_ACK   = sign_ack_q;
    assign bus.RESULT     = result_q;
    assign bus.ERR        = err_q;
    assign bus.RESULT_STB = (state_q == RESULT) || (state_q == ERROR);
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.DEPTH_OUT  = sp_q;
    assign bus.STATE_DBG  = state_q;
endmodule

// File: tb/tb_postfix_eval.sv
// Directed bench for postfix_eval: token drivers, expected-result queue, summary.
module tb_postfix_eval;
    logic CLK;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [18:0] exp_q[$];

    postfix_eval_if #(.DATA_W(16), .DEPTH(8)) bus ();
    postfix_eval #(.DATA_W(16), .DEPTH(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_num(input logic [7:0] v);
        int n = 0;
        bus.NUMBER_IN  = v;
        bus.NUMBER_STB = 1'b1;
        do begin tick(); n++; end while (!bus.NUMBER_ACK && n < 100);
        bus.NUMBER_STB = 1'b0;
        check("num_ack", 32'(bus.NUMBER_ACK), 1);
    endtask

    task automatic send_sign(input logic [7:0] c);
        int n = 0;
        bus.SIGN_IN  = c;
        bus.SIGN_STB = 1'b1;
        do begin tick(); n++; end while (!bus.SIGN_ACK && n < 100);
        bus.SIGN_STB = 1'b0;
        check("sign_ack", 32'(bus.SIGN_ACK), 1);
    endtask

    task automatic send_end();
        int n = 0;
        bus.NUMBER_STB = 1'b1;
        bus.SIGN_STB   = 1'b1;
        do begin tick(); n++; end while (!(bus.NUMBER_ACK && bus.SIGN_ACK) && n < 100);
        bus.NUMBER_STB = 1'b0;
        bus.SIGN_STB   = 1'b0;
        check("end_ack", 32'({bus.NUMBER_ACK, bus.SIGN_ACK}), 3);
    endtask

    task automatic op_timed(input logic [7:0] c, input int exp_busy, input string tag);
        int n = 0;
        send_sign(c);
        while (bus.BUSY && n < 200) begin n++; tick(); end
        check(tag, 32'(n), 32'(exp_busy));
    endtask

    task automatic expect_result(input string tag, input logic [15:0] res, input logic [2:0] err);
        int n = 0;
        logic [18:0] e;
        exp_q.push_back({err, res});
        while (!bus.RESULT_STB && n < 300) begin n++; tick(); end
        check({tag, "_stb"}, 32'(bus.RESULT_STB), 1);
        e = exp_q.pop_front();
        check({tag, "_result"}, 32'(bus.RESULT), 32'(e[15:0]));
        check({tag, "_err"}, 32'(bus.ERR), 32'(e[18:16]));
        tick();
        tick();
        check({tag, "_stb_hold"}, 32'(bus.RESULT_STB), 1);
        bus.RESULT_ACK = 1'b1;
        tick();
        bus.RESULT_ACK = 1'b0;
        check({tag, "_stb_drop"}, 32'(bus.RESULT_STB), 0);
        check({tag, "_depth0"}, 32'(bus.DEPTH_OUT), 0);
        check({tag, "_idle"}, 32'(bus.BUSY), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.BUSY), 0);
        check({tag, "_acks"}, 32'({bus.NUMBER_ACK, bus.SIGN_ACK}), 0);
        check({tag, "_stb"}, 32'(bus.RESULT_STB), 0);
        check({tag, "_result"}, 32'(bus.RESULT), 0);
        check({tag, "_err"}, 32'(bus.ERR), 0);
        check({tag, "_depth"}, 32'(bus.DEPTH_OUT), 0);
        check({tag, "_state"}, 32'(bus.STATE_DBG), 0);
    endtask

    initial begin
        RST            = 1'b1;
        bus.NUMBER_IN  = '0;
        bus.NUMBER_STB = 1'b0;
        bus.SIGN_IN    = '0;
        bus.SIGN_STB   = 1'b0;
        bus.RESULT_ACK = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        RST = 1'b0;
        tick();

        // (3 + 4) * 2 = 14
        send_num(8'd3);
        send_num(8'd4);
        check("depth2", 32'(bus.DEPTH_OUT), 2);
        op_timed(8'd43, 4, "add_latency");
        send_num(8'd2);
        op_timed(8'd42, 4, "mul_latency");
        send_end();
        expect_result("expr14", 16'd14, 3'd0);

        send_num(8'd3); send_num(8'd8); send_sign(8'd45); send_end();
        expect_result("sub_neg", 16'hFFFB, 3'd0);
        send_num(8'd8); send_num(8'd3); send_sign(8'd45); send_end();
        expect_result("sub_pos", 16'd5, 3'd0);

        send_num(8'd7); send_num(8'd2);
        op_timed(8'd47, 20, "div_latency");
        send_end();
        expect_result("div7_2", 16'd3, 3'd0);
        send_num(8'd0); send_num(8'd7); send_sign(8'd45);
        send_num(8'd2); send_sign(8'd47); send_end();
        expect_result("div_neg", 16'hFFFD, 3'd0);

        // Error cases, each followed by a clean expression
        send_num(8'd5); send_num(8'd0); send_sign(8'd47);
        expect_result("div0", 16'd0, 3'd3);
        send_num(8'd1); send_end();
        expect_result("after_div0", 16'd1, 3'd0);

        send_num(8'd5); send_sign(8'd43);
        expect_result("underflow", 16'd0, 3'd1);
        send_num(8'd1); send_end();
        expect_result("after_uflow", 16'd1, 3'd0);

        send_num(8'd5); send_sign(8'd37);
        expect_result("bad_op", 16'd0, 3'd4);
        send_num(8'd1); send_end();
        expect_result("after_badop", 16'd1, 3'd0);

        send_num(8'd5); send_num(8'd6); send_end();
        expect_result("unbal", 16'd0, 3'd5);
        send_num(8'd1); send_end();
        expect_result("after_unbal", 16'd1, 3'd0);

        // Stack overflow, then reset while the error result is pending
        for (int i = 1; i <= 8; i++) send_num(8'(i));
        check("depth_full", 32'(bus.DEPTH_OUT), 8);
        send_num(8'd9);
        check("ovf_stb", 32'(bus.RESULT_STB), 1);
        check("ovf_err", 32'(bus.ERR), 2);
        check("ovf_state", 32'(bus.STATE_DBG), 7);
        send_num(8'd3);
        check("ovf_err_hold", 32'(bus.ERR), 2);
        RST = 1'b1;
        tick();
        check_all_zero("mid_reset");
        RST = 1'b0;
        tick();

        send_num(8'd200); send_num(8'd200);
        op_timed(8'd42, 4, "mul200_latency");
        send_end();
`ifdef POSTFIX_EVAL_SAT_EN
        expect_result("mul200", 16'd32767, 3'd6);
`else
        expect_result("mul200", 16'h9C40, 3'd0);
        // 128 * 256 wraps to most-negative; dividing by -1 wraps back to it
        send_num(8'd128); send_num(8'd255); send_num(8'd1); send_sign(8'd43);
        send_sign(8'd42);
        send_num(8'd0); send_num(8'd1); send_sign(8'd45);
        send_sign(8'd47); send_end();
        expect_result("minneg_div", 16'h8000, 3'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/postfix_eval.md
Name: postfix_eval

Overview:
- Consumes the postfix token stream produced by the infix-to-postfix converter: 8-bit number tokens and ASCII operator tokens ("+", "-", "*", "/").
- Evaluates the expression on an internal operand stack and emits one signed result per expression through a strobe/ack output port.
- Both input strobes high in the same cycle marks end of expression. This is the same convention the converter uses on its own input.

Parameters:
- DATA_W, 16, operand/result width in bits; two's complement. Number tokens are zero-extended to this width.
- DEPTH, 8, operand stack entries; power of two, at least 2.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- BUSY  out  1  high whenever FSM is not IDLE
- NUMBER_IN  in  8  unsigned number token
- NUMBER_STB  in  1  number token valid; held until NUMBER_ACK
- NUMBER_ACK  out  1  one-cycle accept pulse
- SIGN_IN  in  8  ASCII operator token
- SIGN_STB  in  1  operator valid; held until SIGN_ACK
- SIGN_ACK  out  1  one-cycle accept pulse
- RESULT  out  DATA_W  final value; 0 when ERR is nonzero
- ERR  out  3  0 ok, 1 underflow, 2 overflow, 3 divide-by-zero, 4 bad operator, 5 unbalanced end
- RESULT_STB  out  1  RESULT/ERR valid; held until RESULT_ACK
- RESULT_ACK  in  1  consumer accept
- DEPTH_OUT  out  $clog2(DEPTH)+1  current stack occupancy

Behaviour:
- Reset: every output is 0; stack is empty; FSM is in IDLE. RST mid-operation (including mid-divide or while RESULT_STB is high) aborts at once and discards the stack. No result is emitted.
- FSM states: IDLE, POP_B, POP_A, EXEC, DIV, PUSH, RESULT, ERROR.
- IDLE, both strobes high (end of expression):
  - NUMBER_ACK and SIGN_ACK pulse together the next cycle.
  - Depth 1: pop into RESULT and go to RESULT.
  - Any other depth: ERR=5, go to ERROR.
- IDLE, number only:
  - NUMBER_ACK pulses the next cycle, and the value is pushed in that same cycle. FSM stays in IDLE.
  - Stack full: ACK still pulses, ERR=2, go to ERROR.
  - Throughput is one number per 2 cycles; the strobe must drop after ACK.
- IDLE, sign only:
  - SIGN_ACK pulses the next cycle and the operator is latched.
  - SIGN_IN outside {43,45,42,47}: ERR=4, go to ERROR.
  - Depth < 2: ERR=1, go to ERROR.
  - Otherwise go to POP_B.
- POP_B: b = top of stack; pop. Go to POP_A.
- POP_A: a = top of stack; pop. Go to EXEC.
- EXEC:
  - "+" gives a+b; "-" gives a-b; "*" gives the low DATA_W bits of a*b. All go to PUSH.
  - "/" with b==0: ERR=3, go to ERROR.
  - "/" otherwise: go to DIV.
- DIV: iterative restoring divide on magnitudes, one quotient bit per cycle, DATA_W cycles.
  - Quotient is signed and truncates toward zero; the remainder is discarded.
  - Most-negative / -1 wraps to most-negative.
  - Then go to PUSH.
- PUSH: push the result; go to IDLE.
- Operator latency, from SIGN_ACK to back in IDLE:
  - "+", "-", "*": 4 cycles.
  - "/": 4+DATA_W cycles.
- Tokens arriving while BUSY are not acked; the strobe simply stays high.
- RESULT:
  - RESULT_STB is high and ERR=0; the stack is empty.
  - On RESULT_ACK: RESULT_STB drops the next cycle, go to IDLE.
- ERROR:
  - RESULT_STB is high with nonzero ERR. Input tokens are still acked and discarded, except an end-of-expression pair, which is acked and ignored.
  - On RESULT_ACK: stack cleared, ERR and RESULT_STB return to 0, go to IDLE.
- A number and end-of-expression never coincide as separate events; a simultaneous strobe pair is always end of expression.

Optional Feature:
- Macro POSTFIX_EVAL_SAT_EN.
- Defined: "+", "-", "*" and divide-overflow saturate to the signed max/min of DATA_W. The saturation is also reported as ERR=6 on the final result, and RESULT still carries the saturated value.
- Undefined: all of these wrap modulo 2^DATA_W and ERR=6 never occurs.

Test Plan:
- Tokens 3, 4, "+", 2, "*", end -> RESULT=14, ERR=0. RESULT_STB is held until ACK, then drops; DEPTH_OUT returns to 0.
- Tokens 3, 8, "-", end -> RESULT=16'hFFFB (-5); 8, 3, "-", end -> RESULT=5.
- Tokens 7, 2, "/", end -> RESULT=3. BUSY stays high exactly 4+16 cycles after SIGN_ACK. Tokens 0, 7, "-", 2, "/" -> -3.
- Tokens 5, 0, "/" -> ERR=3. Tokens 5, "+" -> ERR=1. Token 5, "%" -> ERR=4. Tokens 5, 6, end -> ERR=5. In each case, after RESULT_ACK the next expression 1, end -> RESULT=1.
- Nine pushes with DEPTH=8 -> ERR=2 on the ninth. Then assert RST while RESULT_STB is high -> all outputs 0 the next cycle.
- Tokens 200, 200, "*", end -> with the macro defined: RESULT=32767, ERR=6; without it: RESULT=16'h9C40, ERR=0.
